// File: rtl/dequantization_stage.sv
// Dequantization stage: multiplies each lane of a quantized DCT coefficient
// row by its entry in a programmable DIM x DIM table, clamps to WIDTH bits,
// and tags the row with its position within the block.

// Per-lane datapath: exact signed product in stage 1, clamp in stage 2.
module dequantization_lane #(
  parameter int WIDTH = 16,
  parameter int QW    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s1_ld_i,
  input  logic             s2_ld_i,
  input  logic [WIDTH-1:0] coef_i,
  input  logic [QW-1:0]    q_i,
  output logic [WIDTH-1:0] coef_o,
  output logic             sat_o
);
  // One extra bit keeps the unsigned table entry positive inside a signed
  // multiply, so the product is always exact.
  localparam int PW = WIDTH + QW + 1;

  logic signed [PW-1:0] x_ext, q_ext, p_d, p_q;
  logic [PW-WIDTH:0]    top;
  logic [WIDTH-1:0]     y_d, y_q;
  logic                 sat_d, sat_q;

  // Stage-1 product: coefficient sign-extended, table entry zero-extended.
  always_comb begin
    x_ext = {{(QW+1){coef_i[WIDTH-1]}}, coef_i};
    q_ext = {{(WIDTH+1){1'b0}}, q_i};
    p_d   = x_ext * q_ext;
  end

  // Stage-2 clamp: the product fits in WIDTH bits only when every bit from
  // the WIDTH-1 position upward is a copy of the sign.
  always_comb begin
    top   = p_q[PW-1:WIDTH-1];
    sat_d = !((&top) || !(|top));
    y_d   = p_q[WIDTH-1:0];
    if (sat_d) begin
      y_d = p_q[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Pipeline registers; each stage only loads when handed a real row.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      p_q   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      if (s1_ld_i) p_q <= p_d;
      if (s2_ld_i) begin
        y_q   <= y_d;
        sat_q <= sat_d;
      end
    end
  end

  assign coef_o = y_q;
  assign sat_o  = sat_q;
endmodule

module dequantization_stage #(
  parameter  int WIDTH = 16,
  parameter  int DIM   = 8,
  parameter  int QW    = 8,
  localparam int IW    = $clog2(DIM),
  localparam int AW    = $clog2(DIM*DIM)
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sob,
  input  logic [DIM-1:0][WIDTH-1:0]  in_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIM-1:0][WIDTH-1:0]  out_row,
  output logic [IW-1:0]              out_row_idx,
  output logic                       out_eob,
  output logic                       out_sat,
  input  logic                       tbl_we,
  input  logic [AW-1:0]              tbl_addr,
  input  logic [QW-1:0]              tbl_data
);
  localparam int STAGES = 2;

  logic [DIM*DIM-1:0][QW-1:0] tbl_q;
  logic [IW-1:0]              rc_q, rc_d, idx_use;
  logic [AW-1:0]              row_base;
  logic [STAGES:1]            vld_pipe_q;
  logic [IW-1:0]              s1_idx_q, s2_idx_q;
  logic                       s2_eob_q;
  logic                       en, accept, s2_ld;
  logic [DIM-1:0]             lane_sat;

  // Whole pipeline advances together whenever the output slot is free.
  assign en       = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign s2_ld    = en && vld_pipe_q[1];

  // Row index for this beat: start-of-block forces row 0, else continue.
  always_comb begin
    idx_use  = in_sob ? '0 : rc_q;
    row_base = AW'(idx_use) * AW'(DIM);
    rc_d     = rc_q;
    if (accept) begin
      rc_d = (idx_use == IW'(DIM-1)) ? '0 : idx_use + IW'(1);
    end
  end

  // Quantization table; a write landing with a beat is seen by the next beat.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int a = 0; a < DIM*DIM; a++) tbl_q[a] <= QW'(1);
    end else if (tbl_we) begin
      tbl_q[tbl_addr] <= tbl_data;
    end
  end

  // Row counter, valid shift register and row-index sideband.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rc_q       <= '0;
      vld_pipe_q <= '0;
      s1_idx_q   <= '0;
      s2_idx_q   <= '0;
      s2_eob_q   <= 1'b0;
    end else begin
      rc_q <= rc_d;
      if (en) vld_pipe_q <= {vld_pipe_q[STAGES-1:1], accept};
      if (accept) s1_idx_q <= idx_use;
      if (s2_ld) begin
        s2_idx_q <= s1_idx_q;
        s2_eob_q <= (s1_idx_q == IW'(DIM-1));
      end
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    dequantization_lane #(.WIDTH(WIDTH), .QW(QW)) u_lane (
      .clk_i  (HCLK),
      .rst_ni (HRESETn),
      .s1_ld_i(accept),
      .s2_ld_i(s2_ld),
      .coef_i (in_row[i]),
      .q_i    (tbl_q[row_base + AW'(i)]),
      .coef_o (out_row[i]),
      .sat_o  (lane_sat[i])
    );
  end

  assign out_valid   = vld_pipe_q[STAGES];
  assign out_row_idx = s2_idx_q;
  assign out_eob     = s2_eob_q;
  assign out_sat     = |lane_sat;
endmodule

// File: tb/tb_dequantization_stage.sv
// Bench for dequantization_stage: a queue-based reference model predicts
// every emitted row; directed sections pin literal values.
module tb_dequantization_stage;
  localparam int WIDTH = 16;
  localparam int DIM   = 8;
  localparam int QW    = 8;

  logic                      HCLK, HRESETn;
  logic                      in_valid, in_ready, in_sob;
  logic [DIM-1:0][WIDTH-1:0] in_row, out_row;
  logic                      out_valid, out_ready, out_eob, out_sat;
  logic [2:0]                out_row_idx;
  logic                      tbl_we;
  logic [5:0]                tbl_addr;
  logic [QW-1:0]             tbl_data;

  dequantization_stage #(.WIDTH(WIDTH), .DIM(DIM), .QW(QW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .in_valid(in_valid), .in_ready(in_ready), .in_sob(in_sob), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_eob(out_eob), .out_sat(out_sat),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [DIM-1:0][WIDTH-1:0] row;
    int                        idx;
    bit                        sat;
  } exp_t;

  int   n_chk = 0, n_fail = 0;
  exp_t mq[$];
  exp_t e;
  int   m_tbl [DIM*DIM];
  int   m_rc, m_idx;
  bit   held;
  logic [DIM-1:0][WIDTH-1:0] h_row, last_row;
  logic [4:0] h_meta;
  int   last_idx, n_out = 0, n_eob = 0;
  bit   last_sat;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact integer product, then clamp to the signed WIDTH range.
  function automatic exp_t model(input logic [DIM-1:0][WIDTH-1:0] row, input int idx);
    exp_t r;
    r.idx = idx;
    r.sat = 0;
    for (int i = 0; i < DIM; i++) begin
      int x, p;
      x = int'($signed(row[i]));
      p = x * m_tbl[idx*DIM + i];
      if (p > 32767)  begin p = 32767;  r.sat = 1; end
      if (p < -32768) begin p = -32768; r.sat = 1; end
      r.row[i] = WIDTH'(p);
    end
    return r;
  endfunction

  function automatic logic [DIM-1:0][WIDTH-1:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [DIM-1:0][WIDTH-1:0] r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
    return r;
  endfunction

  // Compare process: mirrors every handshake into the model and checks outputs.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      mq.delete();
      m_rc = 0;
      for (int a = 0; a < DIM*DIM; a++) m_tbl[a] = 1;
      held = 0;
    end else begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_row", out_row, h_row);
        check("hold_meta", {out_row_idx, out_eob, out_sat}, h_meta);
      end
      if (out_valid && out_ready) begin
        if (mq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_out: got row %h, expected no output", out_row);
        end else begin
          e = mq.pop_front();
          check("out_row", out_row, e.row);
          check("out_idx", out_row_idx, e.idx);
          check("out_eob", out_eob, e.idx == DIM-1);
          check("out_sat", out_sat, e.sat);
        end
        last_row = out_row; last_idx = out_row_idx; last_sat = out_sat;
        n_out++;
        if (out_eob) n_eob++;
      end
      held   = out_valid && !out_ready;
      h_row  = out_row;
      h_meta = {out_row_idx, out_eob, out_sat};
      if (in_valid && in_ready) begin
        m_idx = in_sob ? 0 : m_rc;
        mq.push_back(model(in_row, m_idx));
        m_rc = (m_idx + 1) % DIM;
      end
      if (tbl_we) m_tbl[tbl_addr] = tbl_data;
    end
  end

  task tick();
    @(posedge HCLK); #1;
  endtask

  task automatic send(input bit sob, input logic [DIM-1:0][WIDTH-1:0] row);
    bit ok;
    int guard;
    in_valid = 1; in_sob = sob; in_row = row; guard = 0;
    do begin
      @(negedge HCLK); ok = in_ready; tick(); guard++;
    end while (!ok && guard < 100);
    if (!ok) begin n_chk++; n_fail++; $display("FAIL send_timeout: got in_ready 0, expected 1"); end
    in_valid = 0; in_sob = 0;
  endtask

  task automatic wr(input int addr, input int data);
    tbl_we = 1; tbl_addr = 6'(addr); tbl_data = 8'(data);
    tick();
    tbl_we = 0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((mq.size() != 0 || out_valid) && g < 60) begin tick(); g++; end
    check("drain_empty", mq.size(), 0);
  endtask

  int o0, e0;

  initial begin
    HRESETn = 0; in_valid = 0; in_sob = 0; in_row = '0; out_ready = 1;
    tbl_we = 0; tbl_addr = '0; tbl_data = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1;
    @(negedge HCLK);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_row", out_row, '0);
    check("rst_meta", {out_row_idx, out_eob, out_sat}, 5'd0);
    check("rst_in_ready", in_ready, 1'b1);
    tick();

    // Identity table and two-edge latency.
    send(1, mk(100, -5, 0, 32767, -32768, 1, 2, 3));
    @(negedge HCLK);
    check("lat_not_yet", out_valid, 1'b0);
    tick();
    @(negedge HCLK);
    check("lat_valid", out_valid, 1'b1);
    check("ident_row", out_row, mk(100, -5, 0, 32767, -32768, 1, 2, 3));
    check("ident_idx", out_row_idx, 3'd0);
    check("ident_sat", out_sat, 1'b0);
    tick();

    // Row 1 scaled by 16.
    for (int i = 0; i < DIM; i++) wr(DIM + i, 16);
    send(1, mk(9, 9, 9, 9, 9, 9, 9, 9));
    send(0, mk(1, -2, 3, -4, 5, -6, 7, -8));
    drain();
    check("scale_row", last_row, mk(16, -32, 48, -64, 80, -96, 112, -128));
    check("scale_idx", last_idx, 1);

    // Saturation on row 2 lanes 0/1, zero entry on lane 2.
    wr(16, 255); wr(17, 255); wr(18, 0);
    send(1, '0); send(0, '0);
    send(0, mk(200, -200, 77, 5, 0, 0, 0, 0));
    drain();
    check("sat_row", last_row, mk(32767, -32768, 0, 5, 0, 0, 0, 0));
    check("sat_flag", last_sat, 1'b1);
    send(1, '0); send(0, '0);
    send(0, mk(0, 0, 500, 1, 0, 0, 0, 0));
    drain();
    check("zero_q_row", last_row, mk(0, 0, 0, 1, 0, 0, 0, 0));
    check("zero_q_sat", last_sat, 1'b0);

    // Backpressure: 5-cycle stall in the middle of an 8-row block.
    o0 = n_out; e0 = n_eob;
    fork
      for (int r = 0; r < DIM; r++)
        send(r == 0, mk($urandom_range(0, 300), -r, r, 3, 4, 5, 6, 7));
      begin
        repeat (4) tick();
        out_ready = 0;
        repeat (5) begin
          @(negedge HCLK);
          check("stall_in_ready", in_ready, 1'b0);
          tick();
        end
        out_ready = 1;
      end
    join
    drain();
    check("bp_count", n_out - o0, DIM);
    check("bp_eob", n_eob - e0, 1);

    // Framing: 10 beats, sob on first only; ignored sob; restart at rc=2.
    o0 = n_out; e0 = n_eob;
    for (int b = 0; b < 10; b++) send(b == 0, mk(b, 1, 1, 1, 1, 1, 1, 1));
    drain();
    check("frame_wrap_idx", last_idx, 1);
    in_sob = 1; tick(); in_sob = 0;
    send(0, '0);
    drain();
    check("sob_ignored_idx", last_idx, 2);
    send(1, '0); send(0, '0);
    drain();
    check("restart_idx", last_idx, 1);
    check("frame_eob", n_eob - e0, 1);

    // Table write colliding with a beat reading the same entry.
    tbl_we = 1; tbl_addr = 6'd0; tbl_data = 8'd3;
    send(1, mk(10, 0, 0, 0, 0, 0, 0, 0));
    tbl_we = 0;
    drain();
    check("collide_old", last_row, mk(10, 0, 0, 0, 0, 0, 0, 0));
    send(1, mk(10, 0, 0, 0, 0, 0, 0, 0));
    drain();
    check("collide_new", last_row, mk(30, 0, 0, 0, 0, 0, 0, 0));

    // Reset with two rows in flight.
    out_ready = 0;
    send(1, mk(1, 1, 1, 1, 1, 1, 1, 1));
    send(0, mk(2, 2, 2, 2, 2, 2, 2, 2));
    HRESETn = 0; tick(); HRESETn = 1; out_ready = 1;
    o0 = n_out;
    @(negedge HCLK);
    check("rst_flight_valid", out_valid, 1'b0);
    repeat (5) tick();
    check("rst_flight_none", n_out - o0, 0);
    send(1, mk(10, 0, 0, 0, 0, 0, 0, 0));
    drain();
    check("rst_tbl_restored", last_row, mk(10, 0, 0, 0, 0, 0, 0, 0));

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom % 3) != 0;
      in_sob    = ($urandom % 8) == 0;
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < DIM; i++)
        in_row[i] = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 400) - 200);
      tbl_we   = ($urandom % 5) == 0;
      tbl_addr = 6'($urandom);
      case ($urandom % 4)
        0:       tbl_data = 8'd0;
        1:       tbl_data = 8'd255;
        default: tbl_data = 8'($urandom);
      endcase
      tick();
    end
    in_valid = 0; in_sob = 0; tbl_we = 0; out_ready = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dequantization_stage.md
# dequantization_stage

Inverse of the 2-D DCT compression quantizer: accepts one row of DIM quantized DCT coefficients per beat, multiplies each lane by its entry in a programmable DIM×DIM quantization table, saturates to WIDTH bits and emits the reconstructed row. Sits in the decompression path of the compression AHB peripheral, between the entropy/coefficient unpacker and the inverse-DCT row stage. Two-stage pipeline with valid/ready handshake, full throughput of one row per cycle.

## Interface
- WIDTH, 16, signed coefficient width (input and output lanes)
- DIM, 8, lanes per row and rows per block
- QW, 8, unsigned quantization-table entry width
- HCLK  in  1  clock; all state updates on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- in_valid  in  1  input row present
- in_ready  out  1  stage accepts input this cycle
- in_sob  in  1  start of block; qualifies the accepted row as row 0
- in_row  in  signed [WIDTH-1:0] ×DIM  quantized coefficients, lane 0..DIM-1
- out_valid  out  1  output row present
- out_ready  in  1  downstream accepts output
- out_row  out  signed [WIDTH-1:0] ×DIM  dequantized coefficients
- out_row_idx  out  $clog2(DIM)  block row index of out_row
- out_eob  out  1  out_row is last row of block (out_row_idx == DIM-1)
- out_sat  out  1  at least one lane of out_row was clamped
- tbl_we  in  1  table write strobe
- tbl_addr  in  $clog2(DIM*DIM)  table address = row*DIM + lane
- tbl_data  in  [QW-1:0]  unsigned table entry

## Operation
- Table: DIM*DIM registers of QW bits; reset value 1 (identity). Written on edge where tbl_we=1; writes legal at any time.
- Row counter rc (0..DIM-1), reset 0. Accepted beat = in_valid & in_ready. Row index used for beat: 0 if in_sob else rc. After beat rc ← used+1, wrapping DIM-1 → 0.
- Stage 1 (on accepted beat): per lane p[i] = in_row[i] × {1'b0, Q[idx*DIM+i]}, signed, WIDTH+QW+1 bits, exact; register p, idx, valid.
- Stage 2: per lane clamp p[i] to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; out_sat = OR of clamp events; out_eob = (idx == DIM−1).
- Q entry 0 is legal: lane output 0, not saturated.
- Pipeline enable en = !out_valid | out_ready; in_ready = en (combinational). When en=1 both stages shift (bubbles propagate as valid=0); when en=0 all pipeline registers hold.
- Held output (out_valid=1, out_ready=0): out_row, out_row_idx, out_eob, out_sat stable until accepted.

## Timing
- Reset (HRESETn=0 at edge): out_valid=0, stage-1 valid=0, out_row all 0, out_row_idx=0, out_eob=0, out_sat=0, rc=0, table all 1. Takes effect at that edge regardless of in-flight rows; in-flight rows discarded, never emitted. in_ready=1 in first cycle after reset.
- Latency: row accepted at edge k appears with out_valid=1 after edge k+1 (… stage 2 registered at edge k+1, visible cycle after k+1); continuous rows with out_ready=1 give one row per cycle, order preserved.
- Precisely: accept at edge k → stage 1 loaded at k → stage 2 loaded at k+1 → out_valid high during cycle after edge k+1.
- Table write and accepted beat at same edge, same address: stage 1 uses old entry; new entry applies from next beat.
- in_sob on a beat while rc≠0: block restarts; previous partial block produces no out_eob.
- in_sob ignored when beat not accepted.

## Test plan
- Reset identity: after reset, no table writes, feed row {100,−5,0,32767,−32768,1,2,3} → identical row out, idx 0, out_sat=0, out_valid two edges after acceptance.
- Table scaling: write Q[row1,lane0..7]=16; feed in_sob row then row {1,−2,3,−4,5,−6,7,−8} → second output {16,−32,48,−64,80,−96,112,−128}, idx 1.
- Saturation: Q=255 on lane 0 and 1, inputs 200 and −200 → outputs 32767 and −32768, out_sat=1; Q=0 lane → 0, out_sat unaffected.
- Backpressure: stream 8 rows with in_sob on first, hold out_ready=0 for 5 cycles mid-stream → in_ready=0 while stalled, outputs stable, all 8 rows emitted once in order, out_eob only on idx 7.
- Block framing: 10 beats with in_sob only on beat 0 → idx 0..7,0,1; then in_sob at rc=2 → next idx 0, no eob for truncated block.
- Write collision and reset: tbl_we to address being read on same accepted edge → old value used, next beat new value; assert HRESETn=0 with 2 rows in flight → neither emitted, out_valid=0, table back to 1.
